// File: rtl/addr_map_pkg.sv
// Shared definitions for the address router: FSM states, default ROM/RAM map
// and the data value returned on error responses.
package addr_map_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam logic [31:0] ROM_BASE = 32'h0000_0000;
  localparam logic [31:0] RAM_BASE = 32'h0020_0000;
  localparam logic [4:0]  ROM_LOG2 = 5'd20;
  localparam logic [4:0]  RAM_LOG2 = 5'd23;
  localparam logic [31:0] ERR_DATA = 32'h0000_0000;

endpackage

// File: rtl/region_match.sv
// Combinational hit/offset test of one address against one power-of-two region.
module region_match #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] base,
  input  logic [4:0]        log2,
  output logic              hit,
  output logic [ADDR_W-1:0] offset
);

  logic [ADDR_W-1:0] diff;
  logic [ADDR_W-1:0] ones;
  logic [ADDR_W-1:0] mask;

  // Wrapping subtraction: addresses below base become huge and fail the mask test.
  always_comb begin
    ones   = '1;
    diff   = addr - base;
    mask   = ~(ones << log2);
    hit    = ((diff & ~mask) == '0);
    offset = diff & mask;
  end

endmodule

// File: rtl/addr_router.sv
// Single-outstanding address router: decodes a master request into one of
// NUM_REGIONS targets, waits for ack or timeout, then returns a response.
module addr_router
  import addr_map_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_REGIONS = 2,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {RAM_BASE, ROM_BASE},
  parameter logic [NUM_REGIONS*5-1:0]      REGION_LOG2 = {RAM_LOG2, ROM_LOG2},
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic                          req_we,
  input  logic [DATA_W-1:0]             req_wdata,
  output logic [NUM_REGIONS-1:0]        tgt_valid,
  output logic [ADDR_W-1:0]             tgt_addr,
  output logic                          tgt_we,
  output logic [DATA_W-1:0]             tgt_wdata,
  input  logic [NUM_REGIONS-1:0]        tgt_ack,
  input  logic [NUM_REGIONS*DATA_W-1:0] tgt_rdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          rsp_err
);

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic                     we_q, we_d;
  logic [DATA_W-1:0]        wdata_q, wdata_d;
  logic [NUM_REGIONS-1:0]   sel_q, sel_d;
  logic [ADDR_W-1:0]        tgt_addr_q, tgt_addr_d;
  logic [DATA_W-1:0]        rdata_q, rdata_d;
  logic                     err_q, err_d;
  logic [15:0]              cnt_q, cnt_d;

  logic [NUM_REGIONS-1:0]   hit;
  logic [ADDR_W-1:0]        offs [NUM_REGIONS];
  logic [NUM_REGIONS-1:0]   ack_sel;
  logic [DATA_W-1:0]        ack_data;
  logic                     found;

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_match
    region_match #(.ADDR_W(ADDR_W)) u_match (
      .addr   (addr_q),
      .base   (REGION_BASE[g*ADDR_W +: ADDR_W]),
      .log2   (REGION_LOG2[g*5 +: 5]),
      .hit    (hit[g]),
      .offset (offs[g])
    );
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    sel_d      = sel_q;
    tgt_addr_d = tgt_addr_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    found      = 1'b0;
    ack_sel    = tgt_ack & sel_q;
    ack_data   = '0;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      if (ack_sel[i]) ack_data = ack_data | tgt_rdata[i*DATA_W +: DATA_W];
    end

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          we_d    = req_we;
          wdata_d = req_wdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        sel_d      = '0;
        tgt_addr_d = '0;
        // Lowest-index hit wins when regions overlap.
        for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
          if (hit[i] && !found) begin
            found      = 1'b1;
            sel_d[i]   = 1'b1;
            tgt_addr_d = offs[i];
          end
        end
        if (found) begin
          cnt_d   = '0;
          state_d = ST_ACCESS;
        end else begin
          err_d   = 1'b1;
          rdata_d = DATA_W'(ERR_DATA);
          state_d = ST_RESP;
        end
      end
      ST_ACCESS: begin
        if (|ack_sel) begin
          rdata_d = we_q ? DATA_W'(ERR_DATA) : ack_data;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          rdata_d = DATA_W'(ERR_DATA);
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      sel_q      <= '0;
      tgt_addr_q <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      sel_q      <= sel_d;
      tgt_addr_q <= tgt_addr_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE);
    tgt_valid = (state_q == ST_ACCESS) ? sel_q : '0;
    tgt_addr  = tgt_addr_q;
    tgt_we    = we_q;
    tgt_wdata = wdata_q;
    rsp_valid = (state_q == ST_RESP);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
  end

endmodule

// File: tb/tb_addr_router.sv
// Directed bench for addr_router with the default two-region map and TIMEOUT=4.
module tb_addr_router;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_we = 1'b0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  tgt_valid;
  logic [31:0] tgt_addr;
  logic        tgt_we;
  logic [31:0] tgt_wdata;
  logic [1:0]  tgt_ack = '0;
  logic [63:0] tgt_rdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int passed = 0;

  addr_router #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_we    (req_we),
    .req_wdata (req_wdata),
    .tgt_valid (tgt_valid),
    .tgt_addr  (tgt_addr),
    .tgt_we    (tgt_we),
    .tgt_wdata (tgt_wdata),
    .tgt_ack   (tgt_ack),
    .tgt_rdata (tgt_rdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction; ack_cyc is the 1-based ACCESS cycle in which ack_mask is driven (0 = never).
  task automatic run(input string name, input logic [31:0] addr, input logic we,
                     input logic [31:0] wd, input int ack_cyc, input logic [1:0] ack_mask,
                     input logic [63:0] rdata, input logic [1:0] exp_sel,
                     input logic [31:0] exp_off, input logic exp_err,
                     input logic [31:0] exp_rd, input int exp_lat, input int exp_vcyc,
                     input int hold);
    int lat;
    int vcyc;
    rsp_ready = (hold == 0);
    req_addr  = addr;
    req_we    = we;
    req_wdata = wd;
    req_valid = 1'b1;
    chk({name, ".req_ready"}, 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFF0;
    req_we    = ~we;
    req_wdata = 32'h0;
    lat  = 1;
    vcyc = 0;
    while (!rsp_valid && lat < 20) begin
      if (tgt_valid != '0) begin
        vcyc++;
        if (vcyc == 1) begin
          chk({name, ".tgt_valid"}, 64'(tgt_valid), 64'(exp_sel));
          chk({name, ".tgt_addr"},  64'(tgt_addr),  64'(exp_off));
          chk({name, ".tgt_we"},    64'(tgt_we),    64'(we));
          chk({name, ".tgt_wdata"}, 64'(tgt_wdata), 64'(wd));
        end
        if (vcyc == ack_cyc) begin
          tgt_ack   = ack_mask;
          tgt_rdata = rdata;
        end
      end
      tick();
      tgt_ack = '0;
      lat++;
    end
    chk({name, ".rsp_valid"}, 64'(rsp_valid), 64'd1);
    chk({name, ".latency"},   64'(lat),       64'(exp_lat));
    chk({name, ".tv_cycles"}, 64'(vcyc),      64'(exp_vcyc));
    chk({name, ".rsp_err"},   64'(rsp_err),   64'(exp_err));
    chk({name, ".rsp_rdata"}, 64'(rsp_rdata), 64'(exp_rd));
    chk({name, ".tv_idle"},   64'(tgt_valid), 64'd0);
    for (int k = 0; k < hold; k++) begin
      tick();
      chk({name, ".hold_valid"}, 64'(rsp_valid), 64'd1);
      chk({name, ".hold_rdata"}, 64'(rsp_rdata), 64'(exp_rd));
      chk({name, ".hold_err"},   64'(rsp_err),   64'(exp_err));
      chk({name, ".hold_ready"}, 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    tick();
    chk({name, ".done_valid"}, 64'(rsp_valid), 64'd0);
    chk({name, ".done_ready"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    #2;
    chk("rst.req_ready", 64'(req_ready), 64'd1);
    chk("rst.tgt_valid", 64'(tgt_valid), 64'd0);
    chk("rst.rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst.rsp_err",   64'(rsp_err),   64'd0);
    chk("rst.tgt_addr",  64'(tgt_addr),  64'd0);
    #21 rst_n = 1'b1;
    tick();

    run("rd_rom",   32'h0000_0123, 1'b0, 32'h0, 1, 2'b01, 64'h0000_0000_DEAD_BEEF,
        2'b01, 32'h123, 1'b0, 32'hDEAD_BEEF, 3, 1, 0);
    run("rd_ram0",  32'h0020_0000, 1'b0, 32'h0, 1, 2'b10, 64'hAAAA_5555_1111_2222,
        2'b10, 32'h0, 1'b0, 32'hAAAA_5555, 3, 1, 0);
    run("rd_ramtop", 32'h009F_FFFF, 1'b0, 32'h0, 2, 2'b10, 64'h0BAD_F00D_3333_4444,
        2'b10, 32'h007F_FFFF, 1'b0, 32'h0BAD_F00D, 4, 2, 0);
    tgt_rdata = 64'h9999_8888_7777_6666;
    run("miss_gap", 32'h0010_0000, 1'b0, 32'h0, 0, 2'b00, 64'h9999_8888_7777_6666,
        2'b00, 32'h0, 1'b1, 32'h0, 2, 0, 0);
    run("miss_hi",  32'h00A0_0000, 1'b0, 32'h0, 0, 2'b00, 64'h9999_8888_7777_6666,
        2'b00, 32'h0, 1'b1, 32'h0, 2, 0, 0);
    run("miss_far", 32'h1234_5678, 1'b0, 32'h0, 0, 2'b00, 64'h9999_8888_7777_6666,
        2'b00, 32'h0, 1'b1, 32'h0, 2, 0, 0);
    run("wr_rom",   32'h0000_0400, 1'b1, 32'hCAFE_F00D, 1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF,
        2'b01, 32'h400, 1'b0, 32'h0, 3, 1, 0);
    run("tmo",      32'h0000_0010, 1'b0, 32'h0, 0, 2'b00, 64'h0,
        2'b01, 32'h10, 1'b1, 32'h0, 6, 4, 0);
    run("ack_last", 32'h0000_0010, 1'b0, 32'h0, 4, 2'b01, 64'h0000_0000_1357_2468,
        2'b01, 32'h10, 1'b0, 32'h1357_2468, 6, 4, 0);
    run("wrong_ack", 32'h0000_0020, 1'b0, 32'h0, 1, 2'b10, 64'h5555_5555_6666_6666,
        2'b01, 32'h20, 1'b1, 32'h0, 6, 4, 0);
    run("bp_hold",  32'h0020_0040, 1'b0, 32'h0, 1, 2'b10, 64'h7654_3210_0000_0001,
        2'b10, 32'h40, 1'b0, 32'h7654_3210, 3, 1, 5);

    // Reset pulse while a write is in ACCESS with the target acking.
    req_addr  = 32'h0000_0444;
    req_we    = 1'b1;
    req_wdata = 32'h5A5A_5A5A;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    chk("arst.pre_valid", 64'(tgt_valid), 64'd1);
    chk("arst.pre_we",    64'(tgt_we),    64'd1);
    #2 rst_n = 1'b0;
    tgt_ack = 2'b01;
    #1;
    chk("arst.tgt_valid", 64'(tgt_valid), 64'd0);
    chk("arst.tgt_addr",  64'(tgt_addr),  64'd0);
    chk("arst.tgt_we",    64'(tgt_we),    64'd0);
    chk("arst.tgt_wdata", 64'(tgt_wdata), 64'd0);
    chk("arst.rsp_valid", 64'(rsp_valid), 64'd0);
    chk("arst.rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("arst.rsp_err",   64'(rsp_err),   64'd0);
    chk("arst.req_ready", 64'(req_ready), 64'd1);
    tick();
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("arst.no_rsp", 64'(rsp_valid), 64'd0);
    end
    tgt_ack = '0;
    run("post_rst", 32'h0000_0008, 1'b0, 32'h0, 1, 2'b01, 64'h0000_0000_0F0F_0F0F,
        2'b01, 32'h8, 1'b0, 32'h0F0F_0F0F, 3, 1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed %0d/%0d checks", passed, total);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/addr_router.md
ADDR_ROUTER -- requirements
Module: addr_router

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter NUM_REGIONS, default 2, number of mapped targets (1..8).
REQ-004 SHALL have parameter REGION_BASE, default {32'h0020_0000, 32'h0000_0000}, packed NUM_REGIONS x ADDR_W base table, index 0 in the LSBs.
REQ-005 SHALL have parameter REGION_LOG2, default {5'd23, 5'd20}, packed NUM_REGIONS x 5 size exponent table; region i spans BASE[i] .. BASE[i]+2^LOG2[i]-1.
REQ-006 SHALL have parameter TIMEOUT, default 255, max ACCESS cycles before an error response (1..65535).
REQ-007 clk  in  1  single clock, rising edge.
REQ-008 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-009 req_valid / req_ready  in / out  1  master request handshake.
REQ-010 req_addr  in  ADDR_W  absolute address; req_we  in  1  write when 1; req_wdata  in  DATA_W.
REQ-011 tgt_valid  out  NUM_REGIONS  one-hot target select; tgt_addr  out  ADDR_W  region-relative offset; tgt_we  out  1; tgt_wdata  out  DATA_W.
REQ-012 tgt_ack  in  NUM_REGIONS  per-target completion; tgt_rdata  in  NUM_REGIONS x DATA_W  per-target read data.
REQ-013 rsp_valid / rsp_ready  out / in  1  response handshake; rsp_rdata  out  DATA_W; rsp_err  out  1  unmapped or timed-out access.

Function
REQ-014 SHALL implement FSM IDLE -> DECODE -> ACCESS -> RESP -> IDLE; one transaction outstanding.
REQ-015 IDLE: req_ready=1; on req_valid&req_ready SHALL register addr, we, wdata and go to DECODE; req_ready=0 in all other states.
REQ-016 DECODE (exactly 1 cycle): region i hits when (addr - BASE[i]) < 2^LOG2[i] in ADDR_W-bit unsigned arithmetic; lowest hit index wins on overlap.
REQ-017 DECODE hit: register offset = addr - BASE[i] (masked to LOG2[i] bits), go to ACCESS. Miss: set rsp_err=1, rsp_rdata=0, go directly to RESP.
REQ-018 ACCESS: tgt_valid[i]=1 (only selected bit), tgt_addr/tgt_we/tgt_wdata held stable until ack; tgt_ack bits of unselected targets SHALL be ignored.
REQ-019 ACCESS: on tgt_ack[i] capture tgt_rdata slice i into rsp_rdata (0 on writes), rsp_err=0, go to RESP; tgt_valid drops the same edge.
REQ-020 ACCESS SHALL count cycles from 0; if count reaches TIMEOUT without ack, drop tgt_valid, rsp_err=1, rsp_rdata=0, go to RESP. Ack in the same cycle count reaches TIMEOUT wins (no error).
REQ-021 RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_valid&rsp_ready, then IDLE; rsp_ready asserted on first RESP cycle gives zero-stall return.
REQ-022 Minimum latency accept -> rsp_valid: 3 cycles for hits with same-cycle ack, 2 cycles for misses.
REQ-023 Master request signals outside IDLE SHALL be ignored; back-to-back transactions need no idle bubble beyond the IDLE accept cycle.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, req_ready=1, tgt_valid=0, tgt_addr=0, tgt_we=0, tgt_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout count=0.
REQ-025 Reset mid-ACCESS or mid-RESP SHALL abandon the transaction without any response; first accept possible on the first rising edge after rst_n rises.

Structure
REQ-026 Shared package addr_map_pkg SHALL hold FSM state enum, default ROM/RAM base and LOG2 constants, and the error-data constant 0.
REQ-027 Region match SHALL be one sub-module region_match (combinational, per-region hit + offset), instantiated NUM_REGIONS times by generate.

Verification
REQ-028 Read 0x0000_0123, ack next cycle with 0xDEAD_BEEF on target 0 -> tgt_valid=01, tgt_addr=0x123, rsp_rdata=0xDEAD_BEEF, rsp_err=0.
REQ-029 Read 0x0020_0000 and 0x009F_FFFF -> tgt_valid=10, tgt_addr 0x0 and 0x7F_FFFF respectively.
REQ-030 Reads 0x0010_0000, 0x00A0_0000, 0x1234_5678 -> no tgt_valid, rsp_err=1, rsp_rdata=0, rsp_valid 2 cycles after accept.
REQ-031 TIMEOUT=4, target never acks -> tgt_valid high exactly 4 cycles, then rsp_err=1; repeat with ack on 4th cycle -> rsp_err=0.
REQ-032 Hold rsp_ready=0 for 5 cycles -> rsp_valid and data stable, req_ready=0; pulse rst_n low during ACCESS -> all outputs reset values asynchronously, no response.
